jump_input: RTL and testbench

JUMP_INPUT -- requirements
Module: jump_input

---
 rtl/frogger_pkg.sv | 38 +++
 rtl/debounce.sv | 53 +++++
 rtl/jump_input.sv | 179 +++++++++++++++++
 tb/tb_jump_input.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// ----------------------------------------------------------------------------
// frogger_pkg
// Shared types and constants for the frog jump input path.
//   jump_dir_t      : encoding of a jump request direction
//   HELD_*          : bit positions of each button inside the 4-bit held bus
//   pickDir()       : highest-priority pending direction (fwd > back > left > right)
// ----------------------------------------------------------------------------
package frogger_pkg;

   typedef enum logic [1:0] {
      JUMP_FWD   = 2'd0,
      JUMP_BACK  = 2'd1,
      JUMP_LEFT  = 2'd2,
      JUMP_RIGHT = 2'd3
   } jump_dir_t;

   localparam int HELD_FWD   = 0;
   localparam int HELD_BACK  = 1;
   localparam int HELD_LEFT  = 2;
   localparam int HELD_RIGHT = 3;

   // Forward wins over backward, backward over left, left over right. The
   // caller only uses the result when at least one bit is set.
   function automatic jump_dir_t pickDir(input logic [3:0] pending);
      jump_dir_t dir;
      if (pending[HELD_FWD]) begin
         dir = JUMP_FWD;
      end else if (pending[HELD_BACK]) begin
         dir = JUMP_BACK;
      end else if (pending[HELD_LEFT]) begin
         dir = JUMP_LEFT;
      end else begin
         dir = JUMP_RIGHT;
      end
      return dir;
   endfunction

endpackage

// File: rtl/debounce.sv
// ----------------------------------------------------------------------------
// debounce
// Synchronizes one raw asynchronous button and accepts a level change only
// after it has been seen stable for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   i_raw    in   raw asynchronous button level
//   o_stable out  debounced level
// ----------------------------------------------------------------------------
module debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_stable
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic [CW-1:0] r_count;

   // Two-flop synchronizer, then a counter that runs only while the
   // synchronized level disagrees with the accepted level. Any agreement
   // (a bounce back) restarts the count from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_count  <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_count <= '0;
         end else if (r_count == LAST_COUNT) begin
            r_stable <= r_sync2;
            r_count  <= '0;
         end else begin
            r_count <= r_count + CW'(1);
         end
      end
   end

   assign o_stable = r_stable;

endmodule

// File: rtl/jump_input.sv
// ----------------------------------------------------------------------------
// jump_input
// Turns four raw jump buttons into a stream of single jump requests on a
// valid/ready interface. Each button is debounced; a press (rising debounced
// level) marks that direction pending, and pending directions are issued one
// per handshake in priority order forward > backward > left > right.
// Optional build macro:
//   JUMP_REPEAT_EN  holding a button auto-repeats after REPEAT_DELAY cycles,
//                   then every REPEAT_PERIOD cycles. Undefined: one request
//                   per press.
// Ports:
//   clk             in   pixel clock
//   rst             in   synchronous active-high reset
//   jumpForwardIn   in   raw button, active-high
//   jumpBackwardIn  in   raw button, active-high
//   jumpLeftIn      in   raw button, active-high
//   jumpRightIn     in   raw button, active-high
//   jump_valid      out  request available
//   jump_dir        out  request direction (jump_dir_t encoding)
//   jump_ready      in   consumer accepts the request
//   held            out  debounced levels {right, left, backward, forward}
//   overflow        out  sticky: a press was merged into an already pending one
// ----------------------------------------------------------------------------
module jump_input #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12550000,
   parameter int REPEAT_PERIOD   = 5020000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       jumpForwardIn,
   input  logic       jumpBackwardIn,
   input  logic       jumpLeftIn,
   input  logic       jumpRightIn,
   output logic       jump_valid,
   output logic [1:0] jump_dir,
   input  logic       jump_ready,
   output logic [3:0] held,
   output logic       overflow
);

   import frogger_pkg::*;

   logic [3:0] w_rawIn;
   logic [3:0] w_stable;
   logic [3:0] r_held;
   logic [3:0] r_heldDly;
   logic [3:0] w_rise;
   logic [3:0] w_newReq;
   logic [3:0] r_pending;
   logic [3:0] w_clear;
   logic       w_canLoad;
   jump_dir_t  w_grantDir;
   logic       r_valid;
   logic [1:0] r_dir;
   logic       r_overflow;

   assign w_rawIn[HELD_FWD]   = jumpForwardIn;
   assign w_rawIn[HELD_BACK]  = jumpBackwardIn;
   assign w_rawIn[HELD_LEFT]  = jumpLeftIn;
   assign w_rawIn[HELD_RIGHT] = jumpRightIn;

   for (genvar g = 0; g < 4; g++) begin : g_debounce
      debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .rst     (rst),
         .i_raw   (w_rawIn[g]),
         .o_stable(w_stable[g])
      );
   end

   // held is a registered copy of the debounced levels; the edge detector
   // works off held so a press reaches the pending bits one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_held    <= '0;
         r_heldDly <= '0;
      end else begin
         r_held    <= w_stable;
         r_heldDly <= r_held;
      end
   end

   assign w_rise = r_held & ~r_heldDly;

`ifdef JUMP_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(RPT_MAX + 1);
   localparam logic [RW-1:0] RPT_DELAY_W  = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] RPT_PERIOD_W = RW'(REPEAT_PERIOD);

   logic [RW-1:0] r_rptCnt [4];
   logic [3:0]    r_rptPhase;
   logic [3:0]    w_rptFire;

   // A repeat fires when the hold counter reaches the initial delay, and
   // after the first repeat (phase set) every period thereafter.
   always_comb begin
      w_rptFire = '0;
      for (int i = 0; i < 4; i++) begin
         w_rptFire[i] = r_held[i] &&
                        (r_rptCnt[i] == (r_rptPhase[i] ? RPT_PERIOD_W : RPT_DELAY_W));
      end
   end

   // The counter starts with the press (the cycle the rising edge marks the
   // pending bit) so that the first repeat lands REPEAT_DELAY cycles later.
   // Reloading with 1 on a fire keeps the following interval exact.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            r_rptCnt[i] <= '0;
         end
         r_rptPhase <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!r_held[i]) begin
               r_rptCnt[i]   <= '0;
               r_rptPhase[i] <= 1'b0;
            end else if (w_rptFire[i]) begin
               r_rptCnt[i]   <= RW'(1);
               r_rptPhase[i] <= 1'b1;
            end else begin
               r_rptCnt[i] <= r_rptCnt[i] + RW'(1);
            end
         end
      end
   end

   assign w_newReq = w_rise | w_rptFire;
`else
   logic w_unusedRepeatParams;
   assign w_unusedRepeatParams = ^{REPEAT_DELAY, REPEAT_PERIOD};
   assign w_newReq = w_rise;
`endif

   // The output register may take a new request when it is empty or its
   // current request is being accepted this cycle.
   assign w_canLoad  = (!r_valid || jump_ready) && (|r_pending);
   assign w_grantDir = pickDir(r_pending);

   always_comb begin
      w_clear = '0;
      if (w_canLoad) begin
         w_clear[w_grantDir] = 1'b1;
      end
   end

   // New requests OR into the pending bits after the granted bit is cleared,
   // so a press landing on the clearing cycle simply re-arms that bit. Only a
   // press onto a bit that stays pending counts as a merge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending  <= '0;
         r_overflow <= 1'b0;
         r_valid    <= 1'b0;
         r_dir      <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clear) | w_newReq;
         if (|(w_newReq & r_pending & ~w_clear)) begin
            r_overflow <= 1'b1;
         end
         if (w_canLoad) begin
            r_valid <= 1'b1;
            r_dir   <= w_grantDir;
         end else if (r_valid && jump_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign jump_valid = r_valid;
   assign jump_dir   = r_dir;
   assign held       = r_held;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_jump_input.sv
// ----------------------------------------------------------------------------
// tb_jump_input
// Self-checking bench for jump_input with short debounce/repeat timings.
// Expected directions are queued as presses are driven and compared as the
// DUT hands requests over. Honours JUMP_REPEAT_EN for the hold scenario.
// ----------------------------------------------------------------------------
module tb_jump_input;
   import frogger_pkg::*;

   localparam int DEB = 4;
   localparam int RD  = 20;
   localparam int RP  = 10;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       fwd   = 1'b0;
   logic       back  = 1'b0;
   logic       left  = 1'b0;
   logic       right = 1'b0;
   logic       ready = 1'b0;
   logic       jump_valid;
   logic [1:0] jump_dir;
   logic [3:0] held;
   logic       overflow;

   int checkCount  = 0;
   int passCount   = 0;
   int cyc         = 0;
   int riseCyc     = -1;
   int lastHsCyc   = -1;
   int prevHsCyc   = -1;
   int hsCnt       = 0;
   int validHigh   = 0;
   logic lastValid = 1'b0;
   logic [1:0] expQ [$];

   jump_input #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .jumpForwardIn (fwd),
      .jumpBackwardIn(back),
      .jumpLeftIn    (left),
      .jumpRightIn   (right),
      .jump_valid    (jump_valid),
      .jump_dir      (jump_dir),
      .jump_ready    (ready),
      .held          (held),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic f, input logic b, input logic l, input logic r);
      @(posedge clk);
      #1;
      fwd   = f;
      back  = b;
      left  = l;
      right = r;
   endtask

   task automatic setReady(input logic v);
      @(posedge clk);
      #1;
      ready = v;
   endtask

   task automatic setReset(input logic v);
      @(posedge clk);
      #1;
      rst = v;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor on the falling edge: a request is consumed on the next rising
   // edge whenever valid and ready are both high here.
   always @(negedge clk) begin
      if (!rst) begin
         if (jump_valid && !lastValid) riseCyc = cyc;
         if (jump_valid) validHigh++;
         if (jump_valid && ready) begin
            checkOutput("sbNotEmpty", 32'(expQ.size() != 0), 1);
            if (expQ.size() != 0) begin
               checkOutput("sbDir", jump_dir, expQ.pop_front());
            end
            prevHsCyc = lastHsCyc;
            lastHsCyc = cyc;
            hsCnt++;
         end
      end
      lastValid = rst ? 1'b0 : jump_valid;
   end

   initial begin
      int t0;
      int base;
      int baseValid;
      int expRepeat;

      // Reset state, with a button pressed to show held stays clear
      applyStimulus(1, 0, 0, 0);
      waitCycles(4);
      checkOutput("rstValid", jump_valid, 0);
      checkOutput("rstDir", jump_dir, 0);
      checkOutput("rstHeld", held, 0);
      checkOutput("rstOverflow", overflow, 0);
      applyStimulus(0, 0, 0, 0);
      setReset(0);
      waitCycles(10);
      checkOutput("idleHeld", held, 0);

      // Clean forward press: latency and single-cycle pulse
      setReady(1);
      baseValid = validHigh;
      riseCyc   = -1;
      expQ.push_back(JUMP_FWD);
      applyStimulus(1, 0, 0, 0);
      t0 = cyc + 1;
      waitCycles(14);
      checkOutput("latency", riseCyc, t0 + 8);
      checkOutput("pulseLen", validHigh - baseValid, 1);
      checkOutput("heldFwd", held, 4'b0001);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);
      checkOutput("heldRelease", held, 0);
      checkOutput("drainPress", expQ.size(), 0);

      // Bouncing input: no request; then a steady hold gives exactly one
      base = hsCnt;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 0, 0);
         waitCycles(1);
         applyStimulus(0, 0, 0, 0);
         waitCycles(1);
      end
      waitCycles(8);
      checkOutput("bounceHeld", held, 0);
      checkOutput("bounceNoReq", hsCnt - base, 0);
      expQ.push_back(JUMP_FWD);
      applyStimulus(1, 0, 0, 0);
      waitCycles(20);
      checkOutput("holdOneReq", hsCnt - base, 1);
      checkOutput("holdHeld", held, 4'b0001);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);

      // Simultaneous forward+left with consumer stalled
      setReady(0);
      base = hsCnt;
      expQ.push_back(JUMP_FWD);
      expQ.push_back(JUMP_LEFT);
      applyStimulus(1, 0, 1, 0);
      waitCycles(12);
      checkOutput("stallValid", jump_valid, 1);
      checkOutput("stallDirA", jump_dir, JUMP_FWD);
      waitCycles(10);
      checkOutput("stallDirB", jump_dir, JUMP_FWD);
      checkOutput("stallNoHs", hsCnt - base, 0);
      setReady(1);
      waitCycles(5);
      checkOutput("pairCount", hsCnt - base, 2);
      checkOutput("pairB2B", lastHsCyc - prevHsCyc, 1);
      checkOutput("pairIdle", jump_valid, 0);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);

      // Overflow: output holds one, one pending, third press merges
      setReady(0);
      base = hsCnt;
      expQ.push_back(JUMP_FWD);
      expQ.push_back(JUMP_FWD);
      applyStimulus(1, 0, 0, 0);
      waitCycles(10);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);
      applyStimulus(1, 0, 0, 0);
      waitCycles(10);
      checkOutput("ovfNotYet", overflow, 0);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);
      applyStimulus(1, 0, 0, 0);
      waitCycles(10);
      checkOutput("ovfSet", overflow, 1);
      applyStimulus(0, 0, 0, 0);
      waitCycles(8);
      setReady(1);
      waitCycles(8);
      checkOutput("ovfTwoReq", hsCnt - base, 2);
      checkOutput("ovfSticky", overflow, 1);
      checkOutput("drainOvf", expQ.size(), 0);

      // Reset mid-handshake, button held through reset release
      setReady(0);
      applyStimulus(0, 1, 0, 0);
      waitCycles(12);
      checkOutput("preRstValid", jump_valid, 1);
      setReset(1);
      waitCycles(1);
      checkOutput("rstDropValid", jump_valid, 0);
      checkOutput("rstDropOvf", overflow, 0);
      waitCycles(3);
      checkOutput("rstHoldHeld", held, 0);
      setReady(1);
      base    = hsCnt;
      riseCyc = -1;
      expQ.push_back(JUMP_BACK);
      setReset(0);
      t0 = cyc + 1;
      waitCycles(14);
      checkOutput("rstRelLatency", riseCyc, t0 + 8);
      checkOutput("rstRelOneReq", hsCnt - base, 1);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);

      // All four at once: issued back-to-back in priority order
      base = hsCnt;
      expQ.push_back(JUMP_FWD);
      expQ.push_back(JUMP_BACK);
      expQ.push_back(JUMP_LEFT);
      expQ.push_back(JUMP_RIGHT);
      applyStimulus(1, 1, 1, 1);
      waitCycles(16);
      checkOutput("allCount", hsCnt - base, 4);
      checkOutput("allB2B", lastHsCyc - prevHsCyc, 1);
      checkOutput("allHeld", held, 4'b1111);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);

      // Long hold of right: auto-repeat only when the feature is built in
`ifdef JUMP_REPEAT_EN
      expRepeat = 4;
`else
      expRepeat = 1;
`endif
      base = hsCnt;
      for (int i = 0; i < expRepeat; i++) expQ.push_back(JUMP_RIGHT);
      applyStimulus(0, 0, 0, 1);
      waitCycles(46);
      applyStimulus(0, 0, 0, 0);
      waitCycles(20);
      checkOutput("holdRepeat", hsCnt - base, expRepeat);

      waitCycles(5);
      checkOutput("finalDrain", expQ.size(), 0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
